misao_mem_responder: RTL and testbench

Synthesizable responder for the MISA-O core memory bus: it answers the core's byte-wide fetch/load/store traffic with an on-chip RAM and a small MMIO window. The window holds a GPIO output register, a GPIO input port and a TX byte FIFO drained by an external valid/ready stream. It replaces the behavioural memory model used in the benches and sits directly on the `misao` top-level memory ports. A host-side loader port preloads programs into RAM.

---
 rtl/misao_mem_pkg.sv | 33 +++
 rtl/misao_byte_fifo.sv | 76 +++++++
 rtl/misao_mem_responder.sv | 127 ++++++++++++
 tb/tb_misao_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/misao_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : misao_mem_pkg
// Purpose  : Shared constants for the MISA-O memory responder: the MMIO
//            register offsets, STATUS bit positions, the default MMIO window
//            base, and a helper that packs the STATUS byte.
// Revision : 1.0 - initial release
// ============================================================================
package misao_mem_pkg;

  localparam logic [14:0] MMIO_BASE_DEFAULT = 15'h7F00;

  // Offsets inside the 16-byte MMIO window (mem_addr[3:0])
  localparam logic [3:0] MMIO_GPIO_OUT = 4'h0;
  localparam logic [3:0] MMIO_TX_DATA  = 4'h1;
  localparam logic [3:0] MMIO_STATUS   = 4'h2;
  localparam logic [3:0] MMIO_GPIO_IN  = 4'h3;

  // STATUS = {2'b0, count[2:0], ovf, empty, full}
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 3;

  function automatic logic [7:0] status_byte(input logic [2:0] count,
                                             input logic       ovf,
                                             input logic       empty,
                                             input logic       full);
    return {2'b00, count, ovf, empty, full};
  endfunction

endpackage
`default_nettype wire

// File: rtl/misao_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : misao_byte_fifo
// Purpose  : Byte FIFO for the TX stream. A push into a full FIFO is accepted
//            only when a pop happens on the same edge; otherwise it is dropped
//            and ovf_o pulses for that cycle.
// Ports    : clk, rst (async, active-high)
//            push_i/push_data_i  - enqueue request and byte
//            pop_i               - consumer ready (pop happens only if non-empty)
//            head_o              - byte at the read pointer
//            full_o/empty_o      - occupancy flags
//            count_o             - occupancy 0..DEPTH
//            ovf_o               - combinational pulse: push dropped this cycle
// Revision : 1.0 - initial release
// ============================================================================
module misao_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] count_o,
  output logic       ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q,  count_d;
  logic          pop_fire, push_fire;

  assign full_o    = (count_q == 4'(DEPTH));
  assign empty_o   = (count_q == 4'd0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];

  assign pop_fire  = pop_i & ~empty_o;
  // When full, the slot being popped is the one the write pointer addresses,
  // so a concurrent push can reuse it.
  assign push_fire = push_i & (~full_o | pop_fire);
  assign ovf_o     = push_i & full_o & ~pop_fire;

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_fire && !pop_fire)      count_d = count_q + 4'd1;
    else if (!push_fire && pop_fire) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/misao_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : misao_mem_responder
// Purpose  : Memory responder for the MISA-O core bus. On-chip RAM at
//            0..RAM_DEPTH-1, a 16-byte MMIO window at MMIO_BASE (GPIO out,
//            TX FIFO, STATUS, synchronized GPIO in), and a loader port that
//            has priority over core RAM stores.
// Ports    : clk, rst (async, active-high)
//            mem_*      - core bus; reads are combinational from mem_addr
//            ld_*       - host program loader (RAM only)
//            gpio_in/gpio_out - GPIO pins
//            tx_data/tx_valid/tx_ready - TX byte stream
// Revision : 1.0 - initial release
// ============================================================================
module misao_mem_responder
  import misao_mem_pkg::*;
#(
  parameter int          RAM_DEPTH = 256,
  parameter logic [14:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enable_read,
  input  logic        mem_enable_write,
  input  logic [14:0] mem_addr,
  input  logic        mem_rw,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  mem_data_in,
  input  logic        ld_en,
  input  logic [14:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_DEPTH);

  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] gpio_q;
  logic       ovf_q, ovf_d;
  logic [7:0] sync1_q, sync2_q;

  logic       ram_hit, ld_hit, mmio_hit;
  logic [3:0] offset;
  logic       mmio_wr, tx_push, ovf_clr;
  logic       fifo_full, fifo_empty, fifo_ovf;
  logic [3:0] fifo_count;
  logic       unused_ok;

  // Read strobe and direction flag carry no information: reads are always
  // driven and the write strobe alone decides stores.
  assign unused_ok = ^{mem_enable_read, mem_rw, fifo_count[3]};

  assign ram_hit  = ({1'b0, mem_addr} < 16'(RAM_DEPTH));
  assign ld_hit   = ({1'b0, ld_addr}  < 16'(RAM_DEPTH));
  assign mmio_hit = (mem_addr[14:4] == MMIO_BASE[14:4]);
  assign offset   = mem_addr[3:0];

  assign mmio_wr  = mem_enable_write & mmio_hit;
  assign tx_push  = mmio_wr & (offset == MMIO_TX_DATA);
  assign ovf_clr  = mmio_wr & (offset == MMIO_STATUS) & mem_data_out[STATUS_OVF_BIT];

  // RAM is not reset. Any loader activity blocks the core store that cycle,
  // even when the loader address itself is out of range.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      if (ld_hit) ram_q[ld_addr[RAW-1:0]] <= ld_data;
    end else if (mem_enable_write && ram_hit) begin
      ram_q[mem_addr[RAW-1:0]] <= mem_data_out;
    end
  end

  misao_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_push),
    .push_data_i (mem_data_out),
    .pop_i       (tx_ready),
    .head_o      (tx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .ovf_o       (fifo_ovf)
  );

  assign tx_valid = ~fifo_empty;

  // Set has priority over a coincident clear.
  assign ovf_d = fifo_ovf ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q  <= 8'h00;
      ovf_q   <= 1'b0;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      if (mmio_wr && offset == MMIO_GPIO_OUT) gpio_q <= mem_data_out;
      ovf_q   <= ovf_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign gpio_out = gpio_q;

  always_comb begin
    mem_data_in = 8'h00;
    if (ram_hit) begin
      mem_data_in = ram_q[mem_addr[RAW-1:0]];
    end else if (mmio_hit) begin
      case (offset)
        MMIO_GPIO_OUT: mem_data_in = gpio_q;
        MMIO_STATUS:   mem_data_in = status_byte(fifo_count[2:0], ovf_q,
                                                 fifo_empty, fifo_full);
        MMIO_GPIO_IN:  mem_data_in = sync2_q;
        default:       mem_data_in = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_misao_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_misao_mem_responder
// Purpose  : Directed self-checking bench for misao_mem_responder. TX bytes
//            are queued on a scoreboard when pushed and compared on each pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misao_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [14:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        ld_en;
  logic [14:0] ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  misao_mem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_addr         (mem_addr),
    .mem_rw           (mem_rw),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .ld_en            (ld_en),
    .ld_addr          (ld_addr),
    .ld_data          (ld_data),
    .gpio_in          (gpio_in),
    .gpio_out         (gpio_out),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [14:0] addr, input logic [7:0] exp);
    mem_addr = addr;
    #1;
    check(tag, {24'h0, mem_data_in}, {24'h0, exp});
  endtask

  task automatic core_wr(input logic [14:0] addr, input logic [7:0] data);
    mem_addr         = addr;
    mem_data_out     = data;
    mem_enable_write = 1'b1;
    mem_rw           = 1'b1;
    step();
    mem_enable_write = 1'b0;
    mem_rw           = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] data);
    sb.push_back(data);
    core_wr(15'h7F01, data);
  endtask

  // With tx_ready high, compare every presented byte against the scoreboard
  // until the FIFO empties; a bounded loop guards against a stuck tx_valid.
  task automatic drain(input int exp_n);
    int n = 0;
    logic [7:0] exp_b;
    while (tx_valid && n < 16) begin
      exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check("drain_byte", {24'h0, tx_data}, {24'h0, exp_b});
      step();
      n++;
    end
    check("drain_cycles", n, exp_n);
    check("drain_valid_low", {31'h0, tx_valid}, 32'h0);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; mem_enable_read = 1'b1; mem_enable_write = 1'b0;
    mem_addr = '0; mem_rw = 1'b0; mem_data_out = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; gpio_in = '0; tx_ready = 1'b0;
    step(); step();

    // Reset state
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    rd_check("rst_status", 15'h7F02, 8'h02);
    rst = 1'b0;
    step();

    // Loader write, then loader vs core store collision
    ld_en = 1'b1; ld_addr = 15'h0010; ld_data = 8'hA5;
    step();
    ld_en = 1'b0;
    rd_check("ld_a5", 15'h0010, 8'hA5);
    ld_en = 1'b1; ld_addr = 15'h0010; ld_data = 8'h77;
    core_wr(15'h0010, 8'h3C);
    ld_en = 1'b0;
    rd_check("ld_priority", 15'h0010, 8'h77);
    core_wr(15'h0020, 8'hC3);
    rd_check("core_store", 15'h0020, 8'hC3);
    // Out-of-range loader write must not alias onto 0x10
    ld_en = 1'b1; ld_addr = 15'h0110; ld_data = 8'hEE;
    step();
    ld_en = 1'b0;
    rd_check("ld_out_of_range", 15'h0010, 8'h77);

    // Decode and GPIO
    rd_check("unmapped_read", 15'h0100, 8'h00);
    core_wr(15'h7F00, 8'h5A);
    check("gpio_out_wr", {24'h0, gpio_out}, 32'h5A);
    rd_check("gpio_out_rd", 15'h7F00, 8'h5A);
    core_wr(15'h7F05, 8'hFF);
    check("gpio_after_reserved", {24'h0, gpio_out}, 32'h5A);
    rd_check("reserved_rd", 15'h7F05, 8'h00);
    rd_check("status_after_reserved", 15'h7F02, 8'h02);

    // GPIO_IN synchronizer: visible after two edges
    gpio_in = 8'hB6;
    rd_check("gpio_in_0", 15'h7F03, 8'h00);
    step();
    rd_check("gpio_in_1", 15'h7F03, 8'h00);
    step();
    rd_check("gpio_in_2", 15'h7F03, 8'hB6);

    // FIFO fill and overflow
    tx_ready = 1'b0;
    tx_push(8'h11);
    check("first_valid", {31'h0, tx_valid}, 32'h1);
    check("first_head", {24'h0, tx_data}, 32'h11);
    tx_push(8'h22);
    tx_push(8'h33);
    tx_push(8'h44);
    rd_check("status_full", 15'h7F02, 8'h21);
    core_wr(15'h7F01, 8'h55);
    rd_check("status_ovf", 15'h7F02, 8'h25);
    check("head_stable", {24'h0, tx_data}, 32'h11);
    core_wr(15'h7F02, 8'h04);
    rd_check("status_ovf_clr", 15'h7F02, 8'h21);
    rd_check("tx_data_rd", 15'h7F01, 8'h00);

    // Drain order
    tx_ready = 1'b1;
    drain(4);
    rd_check("status_drained", 15'h7F02, 8'h02);
    tx_ready = 1'b0;

    // Push while full with concurrent pop
    tx_push(8'hAA);
    tx_push(8'hBB);
    tx_push(8'hCC);
    tx_push(8'hDD);
    rd_check("status_full2", 15'h7F02, 8'h21);
    tx_ready = 1'b1;
    check("pop_head", {24'h0, tx_data}, {24'h0, sb.pop_front()});
    tx_push(8'h99);
    tx_ready = 1'b0;
    rd_check("status_push_pop", 15'h7F02, 8'h21);
    tx_ready = 1'b1;
    drain(4);
    tx_ready = 1'b0;

    // Asynchronous reset mid-operation
    tx_push(8'h01);
    tx_push(8'h02);
    tx_push(8'h03);
    rd_check("status_cnt3", 15'h7F02, 8'h18);
    #2;
    rst = 1'b1;
    #1;
    check("async_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("async_gpio_out", {24'h0, gpio_out}, 32'h0);
    sb.delete();
    step();
    rst = 1'b0;
    step();
    rd_check("post_rst_status", 15'h7F02, 8'h02);
    check("post_rst_tx_data", {24'h0, tx_data}, 32'h0);
    rd_check("ram_kept_10", 15'h0010, 8'h77);
    rd_check("ram_kept_20", 15'h0020, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
